// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and 50 MHz default timing for the key conditioner.
package key_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, HELD, REL_PEND} key_state_t;
  localparam int unsigned DEF_NUM_KEYS        = 4;
  localparam int unsigned DEF_CNT_W           = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel, synchronizer + debounce FSM + press/release pulses.
// Auto-repeat of key_press_o while held is built only when BUTTON_REPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o
);
  if (DEBOUNCE_CYCLES < 2 || ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_cnt_chk
    $error("key_debounce_ch: DEBOUNCE_CYCLES must be >=2 and DEBOUNCE_CYCLES-1 must fit in CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_rpt_chk
    $error("key_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be >=1");
  end
  logic sync1_q, s_q;
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, done, rpt_press;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s_q, sync1_q} <= 2'b11;
    else          {s_q, sync1_q} <= {sync1_q, key_n_i};
  assign done = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      RELEASED: if (!s_q) begin state_d = PRESS_PEND; cnt_d = '0; end
      PRESS_PEND:
        if (s_q) state_d = RELEASED;
        else if (done) begin state_d = HELD; press_d = 1'b1; level_d = 1'b1; end
        else cnt_d = cnt_q + CNT_W'(1);
      HELD: if (s_q) begin state_d = REL_PEND; cnt_d = '0; end
      REL_PEND:
        if (!s_q) state_d = HELD;
        else if (done) begin state_d = RELEASED; rel_d = 1'b1; level_d = 1'b0; end
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = RELEASED;
    endcase
  end
`ifdef BUTTON_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic run;
  // Counts only while settled in HELD; after the first repeat it parks at REPEAT_DELAY so it never wraps.
  always_comb begin
    run       = state_q == HELD && !s_q;
    rpt_press = run && (rpt_q == RPT_W'(REPEAT_DELAY - 1) ||
                        rpt_q == RPT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1));
    rpt_d     = run ? (rpt_press ? RPT_W'(REPEAT_DELAY) : rpt_q + RPT_W'(1)) :
                (state_q == HELD || state_q == REL_PEND) ? rpt_q : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rpt_q <= '0;
    else          rpt_q <= rpt_d;
`else
  assign rpt_press = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d | rpt_press;
      rel_q   <= rel_d;
    end
  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = rel_q;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS independent debounced active-low pushbuttons -> levels and strobes.
// Define BUTTON_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_W(CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .key_n_i(key_n[i]),
      .key_level_o(key_level[i]),
      .key_press_o(key_press[i]),
      .key_release_o(key_release[i])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench; a sliding-window debounce model predicts every output cycle.
module tb_key_conditioner;
  localparam int NK = 4, D = 4, RD = 10, RP = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [NK-1:0] key_n = '1, key_level, key_press, key_release;
  typedef struct packed {logic [NK-1:0] lv, pr, rl;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [NK-1:0] kq[$];
  logic [NK-1:0] m_lv = '0, prev_s = '1;
  int run[NK], hc[NK];
  always #5 clk = ~clk;
  key_conditioner #(.NUM_KEYS(NK), .CNT_W(8), .DEBOUNCE_CYCLES(D),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release));
  // A level flips once D+1 consecutive synchronized samples disagree with it; samples lag key_n by 2 edges.
  always @(posedge clk) begin : model
    exp_t e;
    logic [NK-1:0] s;
    e = '0;
    if (!reset_n) begin
      kq.delete();
      kq.push_back({NK{1'b1}});
      kq.push_back({NK{1'b1}});
      m_lv = '0;
      prev_s = '1;
      for (int k = 0; k < NK; k++) begin run[k] = 0; hc[k] = 0; end
    end else begin
      kq.push_back(key_n);
      s = kq.pop_front();
      for (int k = 0; k < NK; k++) begin
        run[k] = (!s[k] != m_lv[k]) ? run[k] + 1 : 0;
`ifdef BUTTON_REPEAT_EN
        if (m_lv[k] && !s[k] && !prev_s[k]) begin
          hc[k]++;
          if (hc[k] == RD || (hc[k] > RD && (hc[k] - RD) % RP == 0)) e.pr[k] = 1'b1;
        end
`endif
        if (run[k] == D + 1) begin
          m_lv[k] = ~m_lv[k];
          if (m_lv[k]) e.pr[k] = 1'b1; else e.rl[k] = 1'b1;
          run[k] = 0;
          hc[k] = 0;
        end
      end
      prev_s = s;
      e.lv = m_lv;
    end
    sb.push_back(e);
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty cycle %0d: no expected entry", cyc);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({key_level, key_press, key_release} !== e) begin
        failures++;
        $display("FAIL outputs cycle %0d: got lv=%b pr=%b rl=%b expected lv=%b pr=%b rl=%b",
                 cyc, key_level, key_press, key_release, e.lv, e.pr, e.rl);
      end
    end
  end
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    int rate;
    key_n = '0;
    hold(3);
    reset_n = 1'b1;
    key_n = 4'b1110;
    hold(12);
    key_n = 4'b1100;
    hold(20);
    key_n = 4'b1110;
    hold(12);
    key_n = '1;
    hold(12);
    for (int i = 0; i < 6; i++) begin key_n[2] = ~key_n[2]; hold(2); end
    key_n[2] = 1'b0;
    hold(12);
    key_n = '1;
    hold(12);
    key_n = '0;
    hold(12);
    key_n = '1;
    hold(12);
    key_n = 4'b0111;
    hold(30);
    key_n[3] = 1'b1;
    hold(2);
    key_n[3] = 1'b0;
    hold(12);
    key_n = '1;
    hold(12);
    key_n = 4'b1101;
    hold(10);
    key_n = 4'b1100;
    hold(5);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== '0) begin
      failures++;
      $display("FAIL async_reset: got lv=%b pr=%b rl=%b required all zero",
               key_level, key_press, key_release);
    end
    hold(2);
    reset_n = 1'b1;
    hold(12);
    key_n = '1;
    hold(12);
    for (int b = 0; b < 20; b++) begin
      rate = $urandom_range(3, 14);
      for (int c = 0; c < 100; c++) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(0, rate - 1) == 0) key_n[k] = ~key_n[k];
        hold(1);
      end
    end
    key_n = '1;
    hold(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
